dispatch_unit: RTL and testbench

Buffers the 103-bit dispatch requests produced by the warp scheduler and routes each one, in order, to the ALU, LSU or special execution unit with a valid/ready handshake. It sits directly downstream of the warp scheduler. Its FIFO-not-full signal is the scheduler's request-FIFO ready. Malformed or overflowing requests are dropped and flagged on a sticky-free per-cycle error word.

---
 rtl/common_pkg.sv | 36 +++
 rtl/sync_fifo.sv | 52 +++++
 rtl/dispatch_unit.sv | 108 ++++++++++
 tb/tb_dispatch_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared request layout and dispatcher error codes for the SP front end.
// The error macros are the canonical codes; the package re-exports them as typed constants.
`ifndef KIANA_SP_ERR_DISPATCH_FIFO_OVERFLOW
`define KIANA_SP_ERR_DISPATCH_FIFO_OVERFLOW 32'h0000_0010
`endif
`ifndef KIANA_SP_ERR_DISPATCH_BAD_UNIT_SEL
`define KIANA_SP_ERR_DISPATCH_BAD_UNIT_SEL 32'h0000_0020
`endif

package common;

    localparam int REQ_W   = 103;
    localparam int WARP_W  = 5;
    localparam int INSTR_W = 63;
    localparam int PRED_W  = 32;
    localparam int UNIT_W  = 3;
    localparam int ERR_W   = 32;

    localparam int WARP_HI     = 102;
    localparam int WARP_LO     = 98;
    localparam int INSTR_HI    = 97;
    localparam int INSTR_LO    = 35;
    localparam int PRED_HI     = 34;
    localparam int PRED_LO     = 3;
    localparam int ALU_BIT     = 2;
    localparam int LSU_BIT     = 1;
    localparam int SPECIAL_BIT = 0;

    localparam logic [ERR_W-1:0] ERR_DISPATCH_FIFO_OVERFLOW = `KIANA_SP_ERR_DISPATCH_FIFO_OVERFLOW;
    localparam logic [ERR_W-1:0] ERR_DISPATCH_BAD_UNIT_SEL  = `KIANA_SP_ERR_DISPATCH_BAD_UNIT_SEL;

    function automatic logic is_one_hot(input logic [UNIT_W-1:0] v);
        return (v != '0) && ((v & (v - 3'd1)) == '0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; head is read combinationally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dispatch_unit.sv
// Buffers scheduler dispatch requests and issues them in order to ALU/LSU/special units.
module dispatch_unit
    import common::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_tvalid_request,
    output logic                   s_tready_request,
    input  logic [REQ_W-1:0]       dispatch_request,
    output logic                   m_tvalid_alu,
    input  logic                   m_tready_alu,
    output logic                   m_tvalid_lsu,
    input  logic                   m_tready_lsu,
    output logic                   m_tvalid_special,
    input  logic                   m_tready_special,
    output logic [WARP_W-1:0]      out_warp_id,
    output logic [INSTR_W-1:0]     out_instruction,
    output logic [PRED_W-1:0]      out_pred,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [ERR_W-1:0]       err
);
    typedef enum logic {ST_EMPTY, ST_HOLD} state_t;

    state_t             state;
    state_t             state_next;
    logic [REQ_W-1:0]   head;
    logic [UNIT_W-1:0]  out_sel;
    logic [ERR_W-1:0]   err_next;
    logic               fifo_full;
    logic               fifo_empty;
    logic               unit_ok;
    logic               push;
    logic               load;
    logic               out_ready;

    assign unit_ok          = is_one_hot(dispatch_request[ALU_BIT:SPECIAL_BIT]);
    assign s_tready_request = !fifo_full;
    assign push             = s_tvalid_request && s_tready_request && unit_ok;

    sync_fifo #(.WIDTH(REQ_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (dispatch_request),
        .pop       (load),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (occupancy)
    );

    // Ready of whichever unit the held request targets.
    assign out_ready = |(out_sel & {m_tready_alu, m_tready_lsu, m_tready_special});

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (!fifo_empty) begin
                    load       = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    load       = !fifo_empty;
                    state_next = fifo_empty ? ST_EMPTY : ST_HOLD;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_comb begin
        err_next = '0;
        if (s_tvalid_request && !s_tready_request) err_next = err_next | ERR_DISPATCH_FIFO_OVERFLOW;
        if (s_tvalid_request && !unit_ok)          err_next = err_next | ERR_DISPATCH_BAD_UNIT_SEL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_EMPTY;
            out_sel         <= '0;
            out_warp_id     <= '0;
            out_instruction <= '0;
            out_pred        <= '0;
            err             <= '0;
        end else begin
            state <= state_next;
            err   <= err_next;
            if (load) begin
                out_sel         <= head[ALU_BIT:SPECIAL_BIT];
                out_warp_id     <= head[WARP_HI:WARP_LO];
                out_instruction <= head[INSTR_HI:INSTR_LO];
                out_pred        <= head[PRED_HI:PRED_LO];
            end
        end
    end

    assign m_tvalid_alu     = (state == ST_HOLD) && out_sel[ALU_BIT];
    assign m_tvalid_lsu     = (state == ST_HOLD) && out_sel[LSU_BIT];
    assign m_tvalid_special = (state == ST_HOLD) && out_sel[SPECIAL_BIT];

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed self-checking bench for dispatch_unit with hand-computed expectations.
module tb_dispatch_unit;
    import common::*;

    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   s_tvalid_request;
    logic                   s_tready_request;
    logic [REQ_W-1:0]       dispatch_request;
    logic                   m_tvalid_alu, m_tready_alu;
    logic                   m_tvalid_lsu, m_tready_lsu;
    logic                   m_tvalid_special, m_tready_special;
    logic [WARP_W-1:0]      out_warp_id;
    logic [INSTR_W-1:0]     out_instruction;
    logic [PRED_W-1:0]      out_pred;
    logic [$clog2(DEPTH):0] occupancy;
    logic [ERR_W-1:0]       err;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] U_ALU = 3'b100;
    localparam logic [2:0] U_LSU = 3'b010;
    localparam logic [2:0] U_SPC = 3'b001;

    dispatch_unit #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .s_tvalid_request (s_tvalid_request),
        .s_tready_request (s_tready_request),
        .dispatch_request (dispatch_request),
        .m_tvalid_alu     (m_tvalid_alu),
        .m_tready_alu     (m_tready_alu),
        .m_tvalid_lsu     (m_tvalid_lsu),
        .m_tready_lsu     (m_tready_lsu),
        .m_tvalid_special (m_tvalid_special),
        .m_tready_special (m_tready_special),
        .out_warp_id      (out_warp_id),
        .out_instruction  (out_instruction),
        .out_pred         (out_pred),
        .occupancy        (occupancy),
        .err              (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs and checks happen 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [REQ_W-1:0] mk_req(input logic [4:0] w, input logic [62:0] ins,
                                                input logic [31:0] p, input logic [2:0] u);
        return {w, ins, p, u};
    endfunction

    task automatic drive(input logic v, input logic [REQ_W-1:0] r);
        s_tvalid_request = v;
        dispatch_request = r;
    endtask

    task automatic check_valids(input string tag, input logic [2:0] exp);
        check(tag, {m_tvalid_alu, m_tvalid_lsu, m_tvalid_special}, exp);
    endtask

    int exp_occ [6] = '{1, 1, 2, 3, 4, 4};

    initial begin
        rst = 1'b1;
        drive(1'b0, '0);
        m_tready_alu = 1'b1; m_tready_lsu = 1'b1; m_tready_special = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_tready", s_tready_request, 1);
        check("rst_occ", occupancy, 0);
        check_valids("rst_valids", 3'b000);
        check("rst_err", err, 0);
        check("rst_warp", out_warp_id, 0);

        // Single ALU request
        drive(1'b1, mk_req(5'd5, 63'h123, 32'hFFFF_FFFF, U_ALU));
        step();
        drive(1'b0, '0);
        check("single_occ1", occupancy, 1);
        check_valids("single_v0", 3'b000);
        step();
        check_valids("single_v1", 3'b100);
        check("single_warp", out_warp_id, 5);
        check("single_instr", out_instruction, 63'h123);
        check("single_pred", out_pred, 32'hFFFF_FFFF);
        check("single_occ0", occupancy, 0);
        step();
        check_valids("single_v2", 3'b000);

        // Full FIFO with LSU stalled, 6th request overflows
        m_tready_lsu = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, mk_req(5'(k), 63'(k), 32'(k), U_LSU));
            step();
            check($sformatf("full_occ%0d", k), occupancy, exp_occ[k-1]);
            check($sformatf("full_vlsu%0d", k), m_tvalid_lsu, (k >= 2));
            check($sformatf("full_err%0d", k), err, (k == 6) ? ERR_DISPATCH_FIFO_OVERFLOW : '0);
            check($sformatf("full_tready%0d", k), s_tready_request, (k < 5));
        end
        drive(1'b0, '0);
        step();
        check("full_err_clear", err, 0);
        check("full_hold_warp", out_warp_id, 1);
        m_tready_lsu = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            step();
            check($sformatf("drain_v%0d", k), m_tvalid_lsu, 1);
            check($sformatf("drain_warp%0d", k), out_warp_id, k);
            check($sformatf("drain_instr%0d", k), out_instruction, k);
        end
        step();
        check_valids("drain_done", 3'b000);
        check("drain_occ", occupancy, 0);
        check("drain_tready", s_tready_request, 1);

        // Head-of-line blocking: stalled ALU holds back a special request
        m_tready_alu = 1'b0;
        drive(1'b1, mk_req(5'd7, 63'h70, 32'h7, U_ALU));
        step();
        drive(1'b1, mk_req(5'd8, 63'h80, 32'h8, U_SPC));
        step();
        drive(1'b0, '0);
        for (int c = 0; c < 3; c++) begin
            check_valids($sformatf("hol_stall%0d", c), 3'b100);
            check($sformatf("hol_warp%0d", c), out_warp_id, 7);
            check($sformatf("hol_occ%0d", c), occupancy, 1);
            if (c < 2) step();
        end
        m_tready_alu = 1'b1;
        step();
        check_valids("hol_special", 3'b001);
        check("hol_special_warp", out_warp_id, 8);
        step();
        check_valids("hol_done", 3'b000);

        // Bad unit selects are dropped and flagged
        drive(1'b1, mk_req(5'd3, 63'h3, 32'h3, 3'b110));
        step();
        check("bad110_err", err, ERR_DISPATCH_BAD_UNIT_SEL);
        check("bad110_occ", occupancy, 0);
        drive(1'b1, mk_req(5'd4, 63'h4, 32'h4, 3'b000));
        step();
        drive(1'b0, '0);
        check("bad000_err", err, ERR_DISPATCH_BAD_UNIT_SEL);
        check("bad000_occ", occupancy, 0);
        step();
        check("bad_err_clear", err, 0);
        check_valids("bad_valids", 3'b000);

        // Pointer wrap: 9 alternating ALU/LSU requests streamed back to back
        for (int k = 1; k <= 10; k++) begin
            if (k <= 9) drive(1'b1, mk_req(5'(k + 10), 63'(k), 32'(k), (k % 2) ? U_ALU : U_LSU));
            else        drive(1'b0, '0);
            step();
            if (k >= 2) begin
                check($sformatf("wrap_warp%0d", k - 1), out_warp_id, k + 9);
                check_valids($sformatf("wrap_v%0d", k - 1), ((k - 1) % 2) ? 3'b100 : 3'b010);
            end
        end
        step();
        check_valids("wrap_done", 3'b000);
        check("wrap_occ", occupancy, 0);

        // Reset with three queued and one held request
        m_tready_lsu = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, mk_req(5'(20 + k), 63'(k), 32'(k), U_LSU));
            step();
        end
        drive(1'b0, '0);
        check("pre_rst_occ", occupancy, 3);
        check_valids("pre_rst_v", 3'b010);
        rst = 1'b1;
        #1;
        check_valids("mid_rst_v", 3'b000);
        check("mid_rst_occ", occupancy, 0);
        check("mid_rst_tready", s_tready_request, 1);
        check("mid_rst_warp", out_warp_id, 0);
        step();
        rst = 1'b0;
        m_tready_lsu = 1'b1;
        drive(1'b1, mk_req(5'd9, 63'h99, 32'hA5A5_A5A5, U_ALU));
        step();
        drive(1'b0, '0);
        step();
        check_valids("post_rst_v", 3'b100);
        check("post_rst_warp", out_warp_id, 9);
        check("post_rst_pred", out_pred, 32'hA5A5_A5A5);
        step();
        check_valids("post_rst_done", 3'b000);
        check("post_rst_occ", occupancy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
